instr_fetch_sequencer: RTL and testbench

Owns the processor timestep counter and the external data path into the shared bus. It fetches instruction and LOAD-immediate words from program memory over a req/ack handshake, advancing `timestep` only when the controller's strobes can take effect. When the controller raises `Ext` and no fetched word is buffered, it stalls the datapath with `exec_en` low. It also provides run/halt/single-step control and a fetch-timeout error.

---
 rtl/instr_fetch_sequencer.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer.sv
// Timestep counter and external-word fetch path for the processor bus.
// Fetches words over a req/ack handshake and stalls the datapath while a needed word is missing.
module instr_fetch_sequencer #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 10,
   parameter int RESET_PC = 0,
   parameter int TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              step,
   input  logic              Ext,
   input  logic              Clr,
   output logic [1:0]        timestep,
   output logic              exec_en,
   output logic [DATA_W-1:0] data,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_HALTED,
      ST_EXEC,
      ST_FETCH,
      ST_ERROR
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          ts_q, ts_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                word_valid_q, word_valid_d;
   logic                single_q, single_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                mem_req_q, mem_req_d;
   logic                halted_q, halted_d;
   logic                err_q, err_d;
   logic                exec_en_c;
   logic                stall_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_HALTED;
         ts_q         <= 2'b00;
         pc_q         <= ADDR_W'(RESET_PC);
         data_q       <= '0;
         word_valid_q <= 1'b0;
         single_q     <= 1'b0;
         cnt_q        <= '0;
         mem_req_q    <= 1'b0;
         halted_q     <= 1'b1;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ts_q         <= ts_d;
         pc_q         <= pc_d;
         data_q       <= data_d;
         word_valid_q <= word_valid_d;
         single_q     <= single_d;
         cnt_q        <= cnt_d;
         mem_req_q    <= mem_req_d;
         halted_q     <= halted_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ts_d         = ts_q;
      pc_d         = pc_q;
      data_d       = data_q;
      word_valid_d = word_valid_q;
      single_d     = single_q;
      cnt_d        = cnt_q;
      exec_en_c    = 1'b0;
      stall_c      = Ext && !word_valid_q;

      case (state_q)
         ST_HALTED: begin
            // run has priority over step, so a simultaneous step never arms single mode
            if (run) begin
               state_d  = ST_EXEC;
               single_d = 1'b0;
            end else if (step) begin
               state_d  = ST_EXEC;
               single_d = 1'b1;
            end
         end
         ST_EXEC: begin
            exec_en_c = !stall_c;
            if (stall_c) begin
               state_d = ST_FETCH;
               cnt_d   = '0;
            end else begin
               ts_d = Clr ? 2'b00 : 2'(ts_q + 2'd1);
               if (Ext) begin
                  word_valid_d = 1'b0;
               end
               if (Clr && (!run || single_q)) begin
                  state_d  = ST_HALTED;
                  single_d = 1'b0;
               end
            end
         end
         ST_FETCH: begin
            // an ack in the final allowed cycle still wins over the timeout
            if (mem_ack) begin
               data_d       = mem_rdata;
               word_valid_d = 1'b1;
               pc_d         = pc_q + ADDR_W'(1);
               state_d      = ST_EXEC;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = ST_ERROR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_ERROR;
         end
      endcase

      mem_req_d = (state_d == ST_FETCH);
      halted_d  = (state_d == ST_HALTED) || (state_d == ST_ERROR);
      err_d     = (state_d == ST_ERROR);
   end

   assign timestep = ts_q;
   assign exec_en  = exec_en_c;
   assign data     = data_q;
   assign mem_req  = mem_req_q;
   assign mem_addr = pc_q;
   assign pc       = pc_q;
   assign halted   = halted_q;
   assign err      = err_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: expands instructions into an expected cycle trace and
// compares the DUT against it every cycle.
module tb_instr_fetch_sequencer;

   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0;
   logic       step = 1'b0;
   logic       Ext = 1'b0;
   logic       Clr = 1'b0;
   logic       mem_ack = 1'b0;
   logic [9:0] mem_rdata = '0;
   logic [1:0] timestep;
   logic       exec_en;
   logic [9:0] data;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic [7:0] pc;
   logic       halted;
   logic       err;

   always #5 clk = ~clk;

   instr_fetch_sequencer #(
      .ADDR_W(8), .DATA_W(10), .RESET_PC(0), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .run(run), .step(step), .Ext(Ext), .Clr(Clr),
      .timestep(timestep), .exec_en(exec_en), .data(data), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pc(pc),
      .halted(halted), .err(err)
   );

   // One cycle of stimulus plus the outputs expected during that cycle.
   typedef struct {
      logic       rst, run, step, ext, clr, ack;
      logic [9:0] rdata;
      logic       chk;
      logic [1:0] ts;
      logic       en, req, hlt, er;
      logic [7:0] pc;
      logic [9:0] data;
   } cyc_t;

   cyc_t       tr[$];
   logic [9:0] word_q[$];
   int         lat_q[$];
   int         g_pc = 0;
   int         g_data = 0;
   int         fetches = 0;
   int         n_pass = 0;
   int         n_total = 0;
   int         seg_no = 0;

   task automatic check(input string nm, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
      else
         n_pass++;
   endtask

   function automatic cyc_t blank();
      cyc_t c;
      c.rst = 0; c.run = 0; c.step = 0;
      c.ext = 1'($urandom); c.clr = 1'($urandom); c.ack = 1'($urandom);
      c.rdata = 10'($urandom_range(0, 1023));
      c.chk = 1; c.ts = 2'b00; c.en = 0; c.req = 0; c.hlt = 0; c.er = 0;
      c.pc = 8'(g_pc); c.data = 10'(g_data);
      return c;
   endfunction

   task automatic add_halted(input logic r, input logic s);
      cyc_t c;
      c = blank();
      c.run = r; c.step = s; c.hlt = 1;
      tr.push_back(c);
   endtask

   task automatic add_reset();
      cyc_t c;
      c = blank();
      c.rst = 1; c.chk = 0;
      tr.push_back(c);
      g_pc = 0;
      g_data = 0;
   endtask

   // Expands one instruction: each Ext timestep costs stall + k fetch cycles + consume.
   task automatic add_instr(input int nts, input logic [7:0] mask, input logic runlvl,
                            input logic randrun);
      cyc_t       c;
      int         lat;
      logic [9:0] word;
      for (int k = 0; k < nts; k++) begin
         logic [1:0] t;
         logic       last;
         t = 2'(k % 4);
         last = (k == nts - 1);
         if (mask[k]) begin
            if (lat_q.size() > 0) lat = lat_q.pop_front();
            else lat = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(1, 4);
            if (word_q.size() > 0) word = word_q.pop_front();
            else word = 10'($urandom_range(0, 1023));
            c = blank();
            c.ext = 1; c.clr = last; c.ts = t;
            tr.push_back(c);
            for (int i = 1; i <= lat; i++) begin
               c = blank();
               c.ext = 1; c.clr = last; c.ts = t; c.req = 1;
               c.ack = (i == lat);
               if (i == lat) c.rdata = word;
               tr.push_back(c);
            end
            g_pc = (g_pc + 1) % 256;
            g_data = int'(word);
            fetches++;
            c = blank();
            c.ext = 1; c.clr = last; c.ts = t; c.en = 1;
            tr.push_back(c);
         end else begin
            c = blank();
            c.ext = 0; c.clr = last; c.ts = t; c.en = 1;
            tr.push_back(c);
         end
      end
   endtask

   // Every cycle added since index s gets its run level; step is noise outside HALTED.
   task automatic set_run(input int s, input logic runlvl, input logic randrun);
      for (int i = s; i < tr.size(); i++) begin
         tr[i].run = randrun ? 1'($urandom) : runlvl;
         tr[i].step = 1'($urandom);
      end
   endtask

   task automatic seg_run(input int ninstr, input int idle);
      int s;
      int d;
      for (int i = 0; i < idle; i++) add_halted(0, 0);
      add_halted(1, 1'($urandom));
      for (int n = 0; n < ninstr; n++) begin
         int nts;
         s = tr.size();
         nts = $urandom_range(1, 6);
         add_instr(nts, 8'($urandom & ((1 << nts) - 1)), 1, 0);
         set_run(s, 1, 0);
      end
      d = $urandom_range(s, tr.size() - 1);
      for (int i = d; i < tr.size(); i++) tr[i].run = 0;
      $display("seg %0d: run burst of %0d instructions, pc now %0d", seg_no++, ninstr, g_pc);
   endtask

   task automatic seg_step(input int idle);
      int s;
      int nts;
      for (int i = 0; i < idle; i++) add_halted(0, 0);
      add_halted(0, 1);
      s = tr.size();
      nts = $urandom_range(1, 6);
      add_instr(nts, 8'($urandom & ((1 << nts) - 1)), 0, 1);
      set_run(s, 0, 1);
      $display("seg %0d: single step, pc now %0d", seg_no++, g_pc);
   endtask

   task automatic seg_timeout();
      cyc_t c;
      int   pre;
      int   s;
      int   nreq;
      add_halted(1, 0);
      pre = $urandom_range(0, 3);
      for (int k = 0; k < pre; k++) begin
         c = blank();
         c.run = 1; c.ext = 0; c.clr = 0; c.ts = 2'(k); c.en = 1;
         tr.push_back(c);
      end
      c = blank();
      c.run = 1; c.ext = 1; c.clr = 0; c.ts = 2'(pre);
      tr.push_back(c);
      s = tr.size();
      for (int i = 0; i < TIMEOUT; i++) begin
         c = blank();
         c.run = 1; c.ext = 1; c.clr = 0; c.ts = 2'(pre); c.req = 1; c.ack = 0;
         tr.push_back(c);
      end
      for (int i = 0; i < 6; i++) begin
         c = blank();
         c.run = 1'($urandom); c.step = 1'($urandom);
         c.ts = 2'(pre); c.hlt = 1; c.er = 1;
         tr.push_back(c);
      end
      nreq = 0;
      for (int i = s; i < tr.size(); i++) nreq += int'(tr[i].req);
      check("pin_timeout_req_cycles", s, 32'(nreq), 32'd15);
      add_reset();
      add_halted(0, 0);
      $display("seg %0d: fetch timeout after %0d plain timesteps, then reset", seg_no++, pre);
   endtask

   task automatic seg_reset_mid_fetch();
      cyc_t c;
      add_halted(1, 0);
      c = blank();
      c.run = 1; c.ext = 1; c.clr = 0;
      tr.push_back(c);
      c = blank();
      c.run = 1; c.ext = 1; c.clr = 0; c.req = 1; c.ack = 0;
      tr.push_back(c);
      c = blank();
      c.rst = 1; c.chk = 0; c.ack = 1;
      tr.push_back(c);
      g_pc = 0;
      g_data = 0;
      add_halted(0, 0);
      $display("seg %0d: reset in the middle of a fetch", seg_no++);
   endtask

   initial begin
      int s;
      int s1;
      int s2;
      int s3;
      int nreq;

      add_reset();
      add_reset();

      // COPY: Ext at ts00, Clr at ts01, word 0x104 acked in the first fetch cycle.
      add_halted(1, 0);
      s = tr.size();
      word_q.push_back(10'h104);
      lat_q.push_back(1);
      add_instr(2, 8'b01, 1, 0);
      set_run(s, 1, 0);
      tr[s + 3].run = 0;
      add_halted(0, 0);
      check("pin_copy_en0", s, 32'(tr[s].en), 32'd0);
      check("pin_copy_en1", s + 1, 32'(tr[s + 1].en), 32'd0);
      check("pin_copy_en2", s + 2, 32'(tr[s + 2].en), 32'd1);
      check("pin_copy_en3", s + 3, 32'(tr[s + 3].en), 32'd1);
      check("pin_copy_ts2", s + 2, 32'(tr[s + 2].ts), 32'd0);
      check("pin_copy_ts3", s + 3, 32'(tr[s + 3].ts), 32'd1);
      check("pin_copy_data", s + 2, 32'(tr[s + 2].data), 32'h104);
      check("pin_copy_after_ts", s + 4, 32'(tr[s + 4].ts), 32'd0);
      check("pin_copy_after_pc", s + 4, 32'(tr[s + 4].pc), 32'd1);
      $display("seg %0d: COPY 0x104", seg_no++);

      // LOAD 0x100 + 0x2AA, ALU word, then a 3-cycle delayed ack, all in one run burst.
      add_halted(1, 0);
      s1 = tr.size();
      word_q.push_back(10'h100);
      word_q.push_back(10'h2AA);
      lat_q.push_back(1);
      lat_q.push_back(1);
      add_instr(2, 8'b11, 1, 0);
      check("pin_load_len", s1, 32'(tr.size() - s1), 32'd6);
      check("pin_load_data", s1 + 5, 32'(tr[s1 + 5].data), 32'h2AA);
      check("pin_load_en", s1 + 5, 32'(tr[s1 + 5].en), 32'd1);
      check("pin_load_ts", s1 + 5, 32'(tr[s1 + 5].ts), 32'd1);
      check("pin_load_pc", s1, 32'(g_pc), 32'd3);
      s2 = tr.size();
      lat_q.push_back(1);
      add_instr(4, 8'b0001, 1, 0);
      check("pin_alu_len", s2, 32'(tr.size() - s2), 32'd6);
      for (int i = 3; i < 6; i++) begin
         check("pin_alu_en", s2 + i, 32'(tr[s2 + i].en), 32'd1);
         check("pin_alu_ts", s2 + i, 32'(tr[s2 + i].ts), 32'(i - 2));
      end
      s3 = tr.size();
      lat_q.push_back(3);
      add_instr(1, 8'b1, 1, 0);
      set_run(s1, 1, 0);
      tr[tr.size() - 1].run = 0;
      nreq = 0;
      for (int i = s3; i < tr.size(); i++) nreq += int'(tr[i].req);
      check("pin_delay_req_cycles", s3, 32'(nreq), 32'd3);
      $display("seg %0d: LOAD, ALU, delayed-ack burst", seg_no++);

      // Halt mid-ALU then single step one more ALU instruction.
      add_halted(1, 0);
      s = tr.size();
      add_instr(4, 8'b0001, 1, 0);
      set_run(s, 1, 0);
      for (int i = s + 4; i < tr.size(); i++) tr[i].run = 0;
      add_halted(0, 0);
      add_halted(0, 1);
      s = tr.size();
      add_instr(4, 8'b0001, 0, 1);
      set_run(s, 0, 1);
      $display("seg %0d: run drop in ALU then single step", seg_no++);

      // Random traffic until the PC has wrapped past 255.
      for (int n = 0; n < 400 && fetches < 300; n++) begin
         if ($urandom_range(0, 3) == 0) seg_step($urandom_range(0, 2));
         else seg_run($urandom_range(1, 4), $urandom_range(0, 2));
      end
      seg_timeout();
      seg_reset_mid_fetch();
      seg_run(3, 1);
      add_halted(0, 0);

      for (int i = 0; i < tr.size(); i++) begin
         @(negedge clk);
         reset = tr[i].rst;
         run = tr[i].run;
         step = tr[i].step;
         Ext = tr[i].ext;
         Clr = tr[i].clr;
         mem_ack = tr[i].ack;
         mem_rdata = tr[i].rdata;
         #1;
         if (tr[i].chk) begin
            check("timestep", i, 32'(timestep), 32'(tr[i].ts));
            check("exec_en", i, 32'(exec_en), 32'(tr[i].en));
            check("mem_req", i, 32'(mem_req), 32'(tr[i].req));
            check("mem_addr", i, 32'(mem_addr), 32'(tr[i].pc));
            check("pc", i, 32'(pc), 32'(tr[i].pc));
            check("data", i, 32'(data), 32'(tr[i].data));
            check("halted", i, 32'(halted), 32'(tr[i].hlt));
            check("err", i, 32'(err), 32'(tr[i].er));
         end
      end
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
